// File: rtl/div_arbiter.sv
// rtl/div_arbiter.sv - round-robin arbiter sharing one iterative divider core
// Zero divisors are answered locally; everything else is issued to the core and awaited.
module div_arbiter #(
    parameter  int width = 6,
    parameter  int n_req = 4,
    localparam int id_w  = $clog2(n_req)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [n_req-1:0]         req,
    input  logic [n_req-1:0]         sign,
    input  logic [n_req*width-1:0]   dividend,
    input  logic [n_req*width-1:0]   divider,
    output logic [n_req-1:0]         ack,
    output logic                     resp_valid,
    input  logic                     resp_ready,
    output logic [id_w-1:0]          resp_id,
    output logic [width-1:0]         quotient,
    output logic [width-1:0]         remainder,
    output logic                     div_by_zero,
    output logic                     busy,
    output logic                     div_start,
    output logic                     div_sign,
    output logic [width-1:0]         div_dividend,
    output logic [width-1:0]         div_divider,
    input  logic                     div_done,
    input  logic [width-1:0]         div_quotient,
    input  logic [width-1:0]         div_remainder
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t           state_q, state_d;
    logic [id_w-1:0]  ptr_q, ptr_d;
    logic [id_w-1:0]  id_q, id_d;
    logic             sign_q, sign_d;
    logic [width-1:0] dd_q, dd_d;
    logic [width-1:0] dv_q, dv_d;
    logic [width-1:0] quot_q, quot_d;
    logic [width-1:0] rem_q, rem_d;
    logic             dbz_q, dbz_d;

    logic             win_found;
    logic [id_w-1:0]  win_idx;
    logic [width-1:0] win_dd;
    logic [width-1:0] win_dv;

    // Rotating priority: the first requester at or after ptr wins.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        for (int k = 0; k < n_req; k++) begin
            if (!win_found && req[id_w'((int'(ptr_q) + k) % n_req)]) begin
                win_found = 1'b1;
                win_idx   = id_w'((int'(ptr_q) + k) % n_req);
            end
        end
    end

    assign win_dd = dividend[int'(win_idx)*width +: width];
    assign win_dv = divider[int'(win_idx)*width +: width];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            id_q    <= '0;
            sign_q  <= 1'b0;
            dd_q    <= '0;
            dv_q    <= '0;
            quot_q  <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            id_q    <= id_d;
            sign_q  <= sign_d;
            dd_q    <= dd_d;
            dv_q    <= dv_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        id_d    = id_q;
        sign_d  = sign_q;
        dd_d    = dd_q;
        dv_d    = dv_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;
        case (state_q)
            IDLE: begin
                if (win_found) begin
                    id_d   = win_idx;
                    sign_d = sign[win_idx];
                    dd_d   = win_dd;
                    dv_d   = win_dv;
                    if (win_dv == '0) begin
                        quot_d  = '1;
                        rem_d   = win_dd;
                        dbz_d   = 1'b1;
                        state_d = RESP;
                    end else begin
                        state_d = ISSUE;
                    end
                end
            end
            ISSUE: state_d = WAIT;
            WAIT: begin
                if (div_done) begin
                    quot_d  = div_quotient;
                    rem_d   = div_remainder;
                    dbz_d   = 1'b0;
                    state_d = RESP;
                end
            end
            RESP: begin
                if (resp_ready) begin
                    ptr_d   = (id_q == id_w'(n_req - 1)) ? '0 : id_q + 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // ack is gated by rst so a requester never drops its request on a grant that reset discards.
    always_comb begin
        ack = '0;
        if (state_q == IDLE && win_found && !rst) begin
            ack[win_idx] = 1'b1;
        end
        busy       = (state_q != IDLE);
        div_start  = (state_q == ISSUE);
        resp_valid = (state_q == RESP);
    end

    assign resp_id      = id_q;
    assign quotient     = quot_q;
    assign remainder    = rem_q;
    assign div_by_zero  = dbz_q;
    assign div_sign     = sign_q;
    assign div_dividend = dd_q;
    assign div_divider  = dv_q;

endmodule

// File: tb/tb_div_arbiter.sv
// tb/tb_div_arbiter.sv - self-checking bench for div_arbiter
// Vector table, multi-cycle corner sequences, then random traffic against a reference model.
module tb_div_arbiter;
    localparam int W  = 6;
    localparam int N  = 4;
    localparam int IW = 2;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req;
    logic [N-1:0]   sign;
    logic [N*W-1:0] dividend;
    logic [N*W-1:0] divider;
    logic [N-1:0]   ack;
    logic           resp_valid;
    logic           resp_ready;
    logic [IW-1:0]  resp_id;
    logic [W-1:0]   quotient;
    logic [W-1:0]   remainder;
    logic           div_by_zero;
    logic           busy;
    logic           div_start;
    logic           div_sign;
    logic [W-1:0]   div_dividend;
    logic [W-1:0]   div_divider;
    logic           div_done = 1'b0;
    logic [W-1:0]   div_quotient = '0;
    logic [W-1:0]   div_remainder = '0;

    div_arbiter #(.width(W), .n_req(N)) dut (
        .clk(clk), .rst(rst), .req(req), .sign(sign),
        .dividend(dividend), .divider(divider), .ack(ack),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
        .quotient(quotient), .remainder(remainder), .div_by_zero(div_by_zero),
        .busy(busy), .div_start(div_start), .div_sign(div_sign),
        .div_dividend(div_dividend), .div_divider(div_divider),
        .div_done(div_done), .div_quotient(div_quotient), .div_remainder(div_remainder)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic void ref_div(input logic sg, input logic [W-1:0] a, input logic [W-1:0] b,
                                    output logic [W-1:0] q, output logic [W-1:0] r);
        int sa, sb;
        if (sg) begin
            sa = int'($signed(a));
            sb = int'($signed(b));
        end else begin
            sa = int'(a);
            sb = int'(b);
        end
        q = W'(sa / sb);
        r = W'(sa % sb);
    endfunction

    // Divider core model: done pulse core_lat cycles after the start cycle.
    int           core_lat = 6;
    int           core_cnt = 0;
    int           done_seen = 0;
    logic         core_st;
    logic [W-1:0] core_q, core_r;

    always @(posedge clk) begin
        core_st = div_start;
        #1;
        div_done = 1'b0;
        if (core_st) begin
            ref_div(div_sign, div_dividend, div_divider, core_q, core_r);
            core_cnt = core_lat;
        end
        if (core_cnt > 0) begin
            core_cnt--;
            if (core_cnt == 0) begin
                div_done      = 1'b1;
                div_quotient  = core_q;
                div_remainder = core_r;
                done_seen++;
            end
        end
    end

    task automatic set_op(input int i, input logic sg, input logic [W-1:0] dd, input logic [W-1:0] dv);
        sign[i]         = sg;
        dividend[i*W +: W] = dd;
        divider[i*W +: W]  = dv;
    endtask

    task automatic wait_ack();
        int n;
        n = 0;
        @(negedge clk);
        while (ack == '0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk("ack_timeout", 32'(n), 32'(0));
    endtask

    task automatic wait_valid();
        int n;
        n = 0;
        @(negedge clk);
        while (!resp_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) chk("valid_timeout", 32'(n), 32'(0));
    endtask

    task automatic do_txn(input int id, input logic sg, input logic [W-1:0] dd, input logic [W-1:0] dv,
                          input logic [W-1:0] eq, input logic [W-1:0] er, input logic ez);
        int n;
        @(posedge clk);
        #1;
        set_op(id, sg, dd, dv);
        req[id] = 1'b1;
        wait_ack();
        chk("ack_onehot", 32'(ack), 32'(1) << id);
        @(posedge clk);
        #1 req[id] = 1'b0;
        @(negedge clk);
        if (dv == '0) begin
            chk("zero_no_start", 32'(div_start), 32'(0));
            chk("zero_valid_next", 32'(resp_valid), 32'(1));
        end else begin
            chk("start_next", 32'(div_start), 32'(1));
            chk("fwd_sign", 32'(div_sign), 32'(sg));
            chk("fwd_dividend", 32'(div_dividend), 32'(dd));
            chk("fwd_divider", 32'(div_divider), 32'(dv));
            @(negedge clk);
            chk("start_one_cycle", 32'(div_start), 32'(0));
            n = 2;
            while (!resp_valid && n < 200) begin
                @(negedge clk);
                n++;
            end
            chk("core_latency", 32'(n), 32'(core_lat + 2));
        end
        chk("resp_id", 32'(resp_id), 32'(id));
        chk("quotient", 32'(quotient), 32'(eq));
        chk("remainder", 32'(remainder), 32'(er));
        chk("div_by_zero", 32'(div_by_zero), 32'(ez));
    endtask

    typedef struct {
        int           id;
        logic         sg;
        logic [W-1:0] dd;
        logic [W-1:0] dv;
        logic [W-1:0] eq;
        logic [W-1:0] er;
        logic         ez;
    } vec_t;

    vec_t vecs[7];
    int   order[7];

    int           ptr_m;
    bit           busy_m;
    int           eid_m;
    logic [W-1:0] eq_m, er_m;
    logic         ez_m;
    int           served;
    logic [N-1:0] acked;

    initial begin
        vecs[0] = '{0, 1'b0, 6'd45, 6'd7,  6'd6,  6'd3,  1'b0};
        vecs[1] = '{1, 1'b0, 6'd13, 6'd0,  6'd63, 6'd13, 1'b1};
        vecs[2] = '{2, 1'b1, 6'd44, 6'd3,  6'd58, 6'd62, 1'b0};
        vecs[3] = '{3, 1'b0, 6'd63, 6'd1,  6'd63, 6'd0,  1'b0};
        vecs[4] = '{0, 1'b1, 6'd63, 6'd0,  6'd63, 6'd63, 1'b1};
        vecs[5] = '{3, 1'b1, 6'd33, 6'd62, 6'd15, 6'd63, 1'b0};
        vecs[6] = '{1, 1'b0, 6'd5,  6'd9,  6'd0,  6'd5,  1'b0};
        order   = '{0, 1, 2, 3, 0, 2, 0};

        rst = 1'b1; req = '0; sign = '0; dividend = '0; divider = '0; resp_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ack", 32'(ack), 32'(0));
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_valid", 32'(resp_valid), 32'(0));
        chk("rst_start", 32'(div_start), 32'(0));
        chk("rst_dbz", 32'(div_by_zero), 32'(0));
        chk("rst_id", 32'(resp_id), 32'(0));
        chk("rst_quot", 32'(quotient), 32'(0));
        chk("rst_rem", 32'(remainder), 32'(0));
        chk("rst_ops", {div_sign, div_dividend, div_divider}, 32'(0));
        @(posedge clk);
        #1 rst = 1'b0;

        for (int v = 0; v < 7; v++)
            do_txn(vecs[v].id, vecs[v].sg, vecs[v].dd, vecs[v].dv, vecs[v].eq, vecs[v].er, vecs[v].ez);

        // Fairness: all requests held from reset, then only 0 and 2 with ptr at 1.
        @(posedge clk);
        #1 rst = 1'b1;
        req = '1;
        for (int i = 0; i < N; i++) set_op(i, 1'b0, 6'(i + 10), 6'd0);
        @(negedge clk);
        chk("ack_gated_in_reset", 32'(ack), 32'(0));
        @(posedge clk);
        #1 rst = 1'b0;
        for (int k = 0; k < 7; k++) begin
            wait_ack();
            chk("fair_order", 32'(ack), 32'(1) << order[k]);
            if (k == 4) begin
                @(posedge clk);
                #1 req = 4'b0101;
            end else if (k == 6) begin
                @(posedge clk);
                #1 req = '0;
            end
        end
        repeat (3) @(negedge clk);

        // Backpressure with req[3] pending.
        @(posedge clk);
        #1 resp_ready = 1'b0;
        set_op(0, 1'b0, 6'd45, 6'd7);
        req[0] = 1'b1;
        wait_ack();
        @(posedge clk);
        #1 req[0] = 1'b0;
        wait_valid();
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            if (c == 0) begin
                set_op(3, 1'b0, 6'd50, 6'd5);
                req[3] = 1'b1;
            end
            @(negedge clk);
            chk("bp_valid", 32'(resp_valid), 32'(1));
            chk("bp_fields", {resp_id, div_by_zero, quotient, remainder}, {2'd0, 1'b0, 6'd6, 6'd3});
            chk("bp_no_ack", 32'(ack), 32'(0));
        end
        @(posedge clk);
        #1 resp_ready = 1'b1;
        @(negedge clk);
        chk("bp_handshake_valid", 32'(resp_valid), 32'(1));
        chk("bp_no_ack_at_handshake", 32'(ack), 32'(0));
        @(negedge clk);
        chk("bp_ack3_after", 32'(ack), 32'(8));
        @(posedge clk);
        #1 req[3] = 1'b0;
        wait_valid();
        chk("bp_next_resp", {resp_id, div_by_zero, quotient, remainder}, {2'd3, 1'b0, 6'd10, 6'd0});

        // Reset while waiting on the core; its late done must be ignored.
        @(posedge clk);
        #1 set_op(1, 1'b0, 6'd20, 6'd4);
        req[1] = 1'b1;
        wait_ack();
        @(posedge clk);
        #1 req[1] = 1'b0;
        @(negedge clk);
        chk("rw_start", 32'(div_start), 32'(1));
        repeat (2) @(negedge clk);
        chk("rw_busy_wait", 32'(busy), 32'(1));
        served = done_seen;
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            chk("rw_busy_low", 32'(busy), 32'(0));
            chk("rw_no_valid", 32'(resp_valid), 32'(0));
        end
        chk("rw_stale_done_seen", 32'(done_seen - served), 32'(1));
        do_txn(2, 1'b0, 6'd30, 6'd4, 6'd7, 6'd2, 1'b0);

        // Random traffic against the reference model.
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        ptr_m = 0; busy_m = 0; served = 0; acked = '0; eid_m = 0;
        eq_m = '0; er_m = '0; ez_m = 1'b0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(posedge clk);
            #1;
            for (int i = 0; i < N; i++) begin
                if (acked[i]) begin
                    if ($urandom_range(1) == 0) req[i] = 1'b0;
                end else if (!req[i]) begin
                    if ($urandom_range(2) == 0) begin
                        set_op(i, 1'($urandom_range(1)), 6'($urandom_range(63)),
                               ($urandom_range(3) == 0) ? 6'd0 : 6'($urandom_range(63, 1)));
                        req[i] = 1'b1;
                    end
                end else if ($urandom_range(19) == 0) begin
                    req[i] = 1'b0;
                end
            end
            acked      = '0;
            resp_ready = ($urandom_range(2) != 0);
            core_lat   = $urandom_range(8, 1);
            @(negedge clk);
            chk("rnd_busy", 32'(busy), 32'(busy_m));
            if (!busy_m) begin
                chk("rnd_idle_no_valid", 32'(resp_valid), 32'(0));
                if (req != '0) begin
                    int w;
                    logic [W-1:0] dd, dv;
                    w = -1;
                    for (int k = 0; k < N; k++)
                        if (w < 0 && req[(ptr_m + k) % N]) w = (ptr_m + k) % N;
                    chk("rnd_ack", 32'(ack), 32'(1) << w);
                    dd = dividend[w*W +: W];
                    dv = divider[w*W +: W];
                    if (dv == '0) begin
                        eq_m = '1; er_m = dd; ez_m = 1'b1;
                    end else begin
                        ref_div(sign[w], dd, dv, eq_m, er_m);
                        ez_m = 1'b0;
                    end
                    eid_m    = w;
                    busy_m   = 1;
                    acked[w] = 1'b1;
                end else begin
                    chk("rnd_no_ack", 32'(ack), 32'(0));
                end
            end else begin
                chk("rnd_no_ack_busy", 32'(ack), 32'(0));
                if (resp_valid) begin
                    chk("rnd_resp", {resp_id, div_by_zero, quotient, remainder},
                        {2'(eid_m), ez_m, eq_m, er_m});
                    if (resp_ready) begin
                        busy_m = 0;
                        ptr_m  = (eid_m + 1) % N;
                        served++;
                    end
                end
            end
        end
        chk("rnd_enough_served", 32'(served > 100), 32'(1));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/div_arbiter.md
# div_arbiter

Round-robin arbiter that shares one iterative divider core among `n_req` requesters. It accepts one request at a time and forwards operands and sign mode to the core. It waits for the core's completion pulse, then returns quotient and remainder to the winning requester over a valid/ready response channel. Divide-by-zero requests are resolved locally and never occupy the core. It sits between the arithmetic clients and the shared divider core.

## Interface
- `width`, 6, operand/result width in bits
- `n_req`, 4, number of requesters (2..8)
- `clk`  in  1  clock, all logic on rising edge
- `rst`  in  1  synchronous, active-high reset
- `req`  in  n_req  per-requester request level
- `sign`  in  n_req  per-requester signed-mode select
- `dividend`  in  n_req*width  flat operand bus; slice i = `[i*width +: width]`
- `divider`  in  n_req*width  flat operand bus, same slicing
- `ack`  out  n_req  one-cycle pulse: operands of requester i captured
- `resp_valid`  out  1  result available
- `resp_ready`  in  1  consumer accepts result
- `resp_id`  out  $clog2(n_req)  index of requester owning the result
- `quotient`  out  width  result quotient
- `remainder`  out  width  result remainder
- `div_by_zero`  out  1  result came from the zero-divisor path
- `busy`  out  1  high in every state except IDLE
- `div_start`  out  1  one-cycle start pulse to the core
- `div_sign`, `div_dividend`, `div_divider`  out  1/width/width  operands to the core, held stable from ISSUE through WAIT
- `div_done`  in  1  core completion pulse
- `div_quotient`, `div_remainder`  in  width  core results, valid in the `div_done` cycle

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE, with any `req` high:
  - Winner = first set bit scanning from `ptr` upward, wrapping at `n_req`.
  - Latch the winner's sign and operands, store the winner in `resp_id`, pulse `ack[winner]`.
  - If the latched divider == 0: quotient = all ones, remainder = raw dividend, `div_by_zero` = 1, go to RESP.
  - Otherwise go to ISSUE.
- ISSUE: `div_start` = 1 for exactly one cycle, go to WAIT.
- WAIT:
  - On `div_done`, latch `div_quotient`/`div_remainder` unchanged, set `div_by_zero` = 0, go to RESP.
  - Otherwise stay in WAIT. There is no timeout.
- RESP: `resp_valid` = 1.
  - When `resp_valid && resp_ready`, set `ptr` = (`resp_id` + 1) mod `n_req` and go to IDLE.
- Requester rules:
  - Hold `req` and operands stable until its `ack`.
  - A `req` still high in the cycle after `ack` counts as a new request.
  - `req` dropped before `ack` is allowed; the request is simply not served.
- `div_done` is ignored in IDLE, ISSUE and RESP; stale completions never produce a response.
- The arbiter performs no sign correction; signed handling is entirely the core's job. `div_sign` is the latched `sign` bit.

## Timing
- Reset state:
  - FSM in IDLE, `ptr` = 0.
  - `ack`, `div_start`, `resp_valid`, `busy`, `div_by_zero` = 0.
  - `resp_id`, `quotient`, `remainder`, `div_*` operands = 0.
- Reset mid-operation: abandon the transaction and return to IDLE the next cycle, with no response. The core may still be running; its later `div_done` is ignored.
- Latency, core path:
  - `ack` in accept cycle T.
  - `div_start` at T+1.
  - If `div_done` arrives at D, `resp_valid` rises at D+1.
- Latency, zero path: `ack` at T, `resp_valid` at T+1.
- Back-to-back: after the response handshake at cycle H, the next `ack` can occur at H+1 at the earliest.
- `resp_valid`, `resp_id`, `quotient`, `remainder`, `div_by_zero` are registered and stay stable while `resp_valid && !resp_ready`.
- No new `ack` is issued while `busy` = 1.

## Test plan
- Unsigned request: req[0], 45 / 7, sign 0 after reset; core model returns 6 / 3 after 6 cycles.
  - Required: `ack[0]` pulse, `div_start` with 45/7 next cycle.
  - Required: `resp_valid` with id 0, quotient 6, remainder 3, `div_by_zero` 0.
- Fairness: all four `req` high from reset and held.
  - Required: service order 0, 1, 2, 3, 0.
  - Then req[0] and req[2] only, with `ptr` = 1: order 2, 0.
- Divide by zero: req[1], dividend 13, divider 0.
  - Required: no `div_start`; `resp_valid` the cycle after `ack`.
  - Required: quotient 63, remainder 13, `div_by_zero` 1, id 1.
- Backpressure: hold `resp_ready` low 5 cycles while req[3] is pending.
  - Required: response fields stable, `ack[3]` not asserted until the cycle after the handshake.
- Reset in WAIT, then `div_done` 3 cycles later.
  - Required: after reset, `busy` 0 and no `resp_valid`; the next request is serviced normally.
- Signed forwarding: req[2], sign 1, dividend 6'd44 (−20), divider 3.
  - Required: `div_sign` 1, operands forwarded unmodified.
  - Required: core results 6'd58 / 6'd62 (−6 / −2) returned bit-exact.
